// File: rtl/uart_pkg.sv
// Shared constants for mem_uart: register offsets, STATUS bit positions,
// minimum divider and TX/RX state encodings.
package uart_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_RSVD   = 2'd3;

   localparam int ST_TX_BUSY   = 0;
   localparam int ST_RX_AVAIL  = 1;
   localparam int ST_RX_FULL   = 2;
   localparam int ST_OVERRUN   = 3;
   localparam int ST_FRAME_ERR = 4;

   localparam logic [15:0] MIN_DIV = 16'd4;

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   typedef struct packed {
      logic frame_err;
      logic overrun;
      logic rx_full;
      logic rx_avail;
      logic tx_busy;
   } status_t;

   function automatic logic [15:0] clamp_div(input logic [15:0] d);
      return (d < MIN_DIV) ? MIN_DIV : d;
   endfunction

endpackage

// File: rtl/mem_uart_if.sv
// iomem valid/ready word bus as seen by a mem_* peripheral.
interface mem_uart_if;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;

   modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                   input  mem_ready, mem_rdata);
   modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                   output mem_ready, mem_rdata);
endinterface

// File: rtl/uart_fifo.sv
// Byte FIFO of 2**LOG2 entries; push while full is dropped unless a pop
// happens in the same cycle.
module uart_fifo #(
   parameter int LOG2 = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [7:0]      din_i,
   output logic [7:0]      dout_o,
   output logic            full_o,
   output logic            empty_o,
   output logic [LOG2:0]   count_o
);
   localparam int DEPTH = 1 << LOG2;

   logic [7:0]      mem_q [DEPTH];
   logic [LOG2-1:0] wr_q, rd_q;
   logic [LOG2:0]   cnt_q;
   logic            do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (LOG2+1)'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + (LOG2)'(1);
         if (do_pop)  rd_q <= rd_q + (LOG2)'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (LOG2+1)'(1);
            2'b01:   cnt_q <= cnt_q - (LOG2+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: rtl/mem_uart.sv
// mem_uart: memory-mapped 8N1 UART on the iomem valid/ready bus.
// Define MEM_UART_RX_FIFO_EN for a 2**RX_FIFO_LOG2-byte RX FIFO; otherwise a single holding register.
module mem_uart
   import uart_pkg::*;
#(
   parameter int DEFAULT_DIV  = 139,
   parameter int RX_FIFO_LOG2 = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   mem_uart_if.slave bus,
   output logic      uart_tx_o,
   input  logic      uart_rx_i
);
`ifdef MEM_UART_RX_FIFO_EN
   localparam int RX_DEPTH = 1 << RX_FIFO_LOG2;
`else
   localparam int RX_DEPTH = 1;
`endif

   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic [15:0] div_q, div_d, div_new;
   logic [1:0]  sel;
   logic        acc, is_wr, stall, done, tx_load, rx_pop, st_wr, div_wr;
   logic        tx_busy, rx_avail, rx_full, rx_push, ovr_set, fe_set;
   logic [7:0]  rx_dout;
   logic [RX_FIFO_LOG2:0] rx_count;
   logic        ovr_q, ovr_d, fe_q, fe_d;
   status_t     status;
   logic        unused_bits;

   assign unused_bits = ^{bus.mem_addr[31:4], bus.mem_addr[1:0],
                          bus.mem_wdata[31:16], bus.mem_wstrb[3:2]};

   // ---------------- bus decode ----------------
   assign sel     = bus.mem_addr[3:2];
   assign is_wr   = |bus.mem_wstrb;
   assign acc     = bus.mem_valid & ~ready_q;
   // A TX byte write waits for the transmitter rather than being dropped.
   assign stall   = bus.mem_wstrb[0] & (sel == REG_DATA) & tx_busy;
   assign done    = acc & ~stall;
   assign tx_load = done & bus.mem_wstrb[0] & (sel == REG_DATA);
   assign rx_pop  = done & ~is_wr & (sel == REG_DATA) & rx_avail;
   assign st_wr   = done & bus.mem_wstrb[0] & (sel == REG_STATUS);
   assign div_wr  = done & is_wr & (sel == REG_DIV);

   assign status  = {fe_q, ovr_q, rx_full, rx_avail, tx_busy};

   always_comb begin
      div_new = div_q;
      if (bus.mem_wstrb[0]) div_new[7:0]  = bus.mem_wdata[7:0];
      if (bus.mem_wstrb[1]) div_new[15:8] = bus.mem_wdata[15:8];
      div_d = div_wr ? clamp_div(div_new) : div_q;
   end

   always_comb begin
      ready_d = done;
      rdata_d = rdata_q;
      if (done) begin
         rdata_d = '0;
         if (!is_wr) begin
            case (sel)
               REG_DATA:   rdata_d = rx_avail ? {24'h0, rx_dout} : 32'hFFFF_FFFF;
               REG_STATUS: rdata_d = {27'h0, status};
               REG_DIV:    rdata_d = {16'h0, div_q};
               default:    rdata_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
         div_q   <= 16'(DEFAULT_DIV);
      end else begin
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         div_q   <= div_d;
      end
   end

   assign bus.mem_ready = ready_q;
   assign bus.mem_rdata = rdata_q;

   // ---------------- transmitter ----------------
   logic [1:0]  tx_st_q, tx_st_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic        tx_go_q, tx_go_d, tx_q, tx_d;

   // tx_go_q holds an accepted byte for one cycle so the line drops the cycle after mem_ready.
   assign tx_busy = (tx_st_q != TX_IDLE) | tx_go_q;

   always_comb begin
      tx_st_d  = tx_st_q;
      tx_cnt_d = tx_cnt_q;
      tx_bit_d = tx_bit_q;
      tx_sh_d  = tx_sh_q;
      tx_go_d  = tx_go_q;
      tx_d     = tx_q;
      if (tx_load) begin
         tx_sh_d = bus.mem_wdata[7:0];
         tx_go_d = 1'b1;
      end
      if (tx_st_q == TX_IDLE) begin
         if (tx_go_q) begin
            tx_st_d  = TX_START;
            tx_go_d  = 1'b0;
            tx_d     = 1'b0;
            tx_cnt_d = div_q - 16'd1;
         end
      end else if (tx_cnt_q != 16'd0) begin
         tx_cnt_d = tx_cnt_q - 16'd1;
      end else begin
         tx_cnt_d = div_q - 16'd1;
         case (tx_st_q)
            TX_START: begin
               tx_st_d  = TX_DATA;
               tx_d     = tx_sh_q[0];
               tx_sh_d  = tx_sh_q >> 1;
               tx_bit_d = 3'd0;
            end
            TX_DATA: begin
               if (tx_bit_q == 3'd7) begin
                  tx_st_d = TX_STOP;
                  tx_d    = 1'b1;
               end else begin
                  tx_d     = tx_sh_q[0];
                  tx_sh_d  = tx_sh_q >> 1;
                  tx_bit_d = tx_bit_q + 3'd1;
               end
            end
            default: begin
               tx_st_d = TX_IDLE;
               tx_d    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_st_q  <= TX_IDLE;
         tx_cnt_q <= '0;
         tx_bit_q <= '0;
         tx_sh_q  <= '0;
         tx_go_q  <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         tx_st_q  <= tx_st_d;
         tx_cnt_q <= tx_cnt_d;
         tx_bit_q <= tx_bit_d;
         tx_sh_q  <= tx_sh_d;
         tx_go_q  <= tx_go_d;
         tx_q     <= tx_d;
      end
   end

   assign uart_tx_o = tx_q;

   // ---------------- receiver ----------------
   logic        rx_s1_q, rx_s2_q, rx_prev_q;
   logic [1:0]  rx_st_q, rx_st_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_sh_q, rx_sh_d;

   always_comb begin
      rx_st_d  = rx_st_q;
      rx_cnt_d = rx_cnt_q;
      rx_bit_d = rx_bit_q;
      rx_sh_d  = rx_sh_q;
      rx_push  = 1'b0;
      fe_set   = 1'b0;
      if (rx_st_q == RX_IDLE) begin
         if (rx_prev_q & ~rx_s2_q) begin
            rx_st_d  = RX_START;
            rx_cnt_d = (div_q >> 1) - 16'd1;
         end
      end else if (rx_cnt_q != 16'd0) begin
         rx_cnt_d = rx_cnt_q - 16'd1;
      end else begin
         rx_cnt_d = div_q - 16'd1;
         case (rx_st_q)
            RX_START: begin
               if (rx_s2_q) rx_st_d = RX_IDLE;
               else begin
                  rx_st_d  = RX_DATA;
                  rx_bit_d = 3'd0;
               end
            end
            RX_DATA: begin
               rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            default: begin
               rx_st_d = RX_IDLE;
               rx_push = rx_s2_q;
               fe_set  = ~rx_s2_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         rx_st_q   <= RX_IDLE;
         rx_cnt_q  <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
      end else begin
         rx_s1_q   <= uart_rx_i;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         rx_st_q   <= rx_st_d;
         rx_cnt_q  <= rx_cnt_d;
         rx_bit_q  <= rx_bit_d;
         rx_sh_q   <= rx_sh_d;
      end
   end

   // ---------------- RX storage ----------------
`ifdef MEM_UART_RX_FIFO_EN
   logic fifo_full, fifo_empty;

   uart_fifo #(.LOG2(RX_FIFO_LOG2)) u_rx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (rx_push),
      .pop_i   (rx_pop),
      .din_i   (rx_sh_q),
      .dout_o  (rx_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (rx_count)
   );

   assign rx_avail = ~fifo_empty;
   assign ovr_set  = rx_push & fifo_full & ~rx_pop;
`else
   logic [7:0] hold_q;
   logic       hold_v_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q   <= '0;
         hold_v_q <= 1'b0;
      end else if (rx_push & (~hold_v_q | rx_pop)) begin
         hold_q   <= rx_sh_q;
         hold_v_q <= 1'b1;
      end else if (rx_pop) begin
         hold_v_q <= 1'b0;
      end
   end

   assign rx_dout  = hold_q;
   assign rx_avail = hold_v_q;
   assign rx_count = (RX_FIFO_LOG2+1)'(hold_v_q);
   assign ovr_set  = rx_push & hold_v_q & ~rx_pop;
`endif

   assign rx_full = (rx_count == (RX_FIFO_LOG2+1)'(RX_DEPTH));

   // Sticky flags: a set in the same cycle as a W1C clear wins.
   assign ovr_d = ovr_set | (ovr_q & ~(st_wr & bus.mem_wdata[ST_OVERRUN]));
   assign fe_d  = fe_set  | (fe_q  & ~(st_wr & bus.mem_wdata[ST_FRAME_ERR]));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr_q <= 1'b0;
         fe_q  <= 1'b0;
      end else begin
         ovr_q <= ovr_d;
         fe_q  <= fe_d;
      end
   end
endmodule

// File: tb/tb_mem_uart.sv
// Self-checking bench for mem_uart: register vectors, TX/RX frames, stall,
// overrun/frame-error/glitch sequences and randomized traffic against a queue model.
module tb_mem_uart;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic uart_tx;
   logic uart_rx = 1'b1;

   mem_uart_if bus();

   mem_uart #(.DEFAULT_DIV(139), .RX_FIFO_LOG2(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .uart_tx_o (uart_tx),
      .uart_rx_i (uart_rx)
   );

   always #5 clk = ~clk;

`ifdef MEM_UART_RX_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif
   localparam logic [31:0] BASE = 32'h0301_0000;
   localparam logic [1:0]  A_DATA = 2'd0, A_STAT = 2'd1, A_DIV = 2'd2, A_RSVD = 2'd3;

   int errors = 0;
   int checks = 0;

   // reference model: RX bytes waiting to be read, sticky flags
   logic [7:0] model_q[$];
   logic       m_ovr = 1'b0;
   logic       m_fe  = 1'b0;

   typedef struct {
      logic [1:0]  r;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic [31:0] exp;
      string       nm;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic bus_xfer(input logic [1:0] r, input logic [31:0] wd, input logic [3:0] ws,
                           output logic [31:0] rd, output int cyc);
      @(negedge clk);
      bus.mem_valid = 1'b1;
      bus.mem_addr  = BASE | {28'h0, r, 2'b00};
      bus.mem_wdata = wd;
      bus.mem_wstrb = ws;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus.mem_ready !== 1'b1 && cyc < 5000);
      if (bus.mem_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL bus_timeout: no mem_ready after %0d cycles", cyc);
      end
      rd = bus.mem_rdata;
      bus.mem_valid = 1'b0;
      bus.mem_wstrb = 4'h0;
   endtask

   task automatic rd_chk(input logic [1:0] r, input logic [31:0] exp, input string name);
      logic [31:0] rd;
      int          cyc;
      bus_xfer(r, 32'h0, 4'h0, rd, cyc);
      chk(name, rd, exp);
   endtask

   task automatic wr(input logic [1:0] r, input logic [31:0] wd);
      logic [31:0] rd;
      int          cyc;
      bus_xfer(r, wd, 4'hF, rd, cyc);
   endtask

   task automatic status_chk(input string name);
      logic [31:0] exp;
      exp = {27'h0, m_fe, m_ovr, model_q.size() == DEPTH, model_q.size() != 0, 1'b0};
      rd_chk(A_STAT, exp, name);
   endtask

   task automatic pop_chk(input string name);
      logic [31:0] exp;
      if (model_q.size() > 0) exp = {24'h0, model_q.pop_front()};
      else exp = 32'hFFFF_FFFF;
      rd_chk(A_DATA, exp, name);
   endtask

   function automatic void model_push(input logic [7:0] b);
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else m_ovr = 1'b1;
   endfunction

   task automatic rx_send(input logic [7:0] b, input logic stopb, input int div);
      uart_rx = 1'b0;
      repeat (div) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (div) @(negedge clk);
      end
      uart_rx = stopb;
      repeat (div) @(negedge clk);
      uart_rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Waits for the start bit, checks its latency, then every clock of all 10 bits.
   task automatic tx_frame_chk(input logic [7:0] b, input int div, input int exp_lat, input string name);
      logic [9:0] fb;
      int         n, bad;
      fb = {1'b1, b, 1'b0};
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (uart_tx !== 1'b0 && n < 20000);
      chk({name, "_lat"}, n, exp_lat);
      for (int k = 0; k < 10; k++) begin
         bad = 0;
         for (int j = 0; j < div; j++) begin
            if (!(k == 0 && j == 0)) @(negedge clk);
            if (uart_tx !== fb[k]) bad++;
         end
         chk($sformatf("%s_bit%0d", name, k), bad, 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int          cyc, div;
      logic [7:0]  b;

      bus.mem_valid = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_wstrb = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx", {31'h0, uart_tx}, 32'h1);
      chk("rst_ready", {31'h0, bus.mem_ready}, 32'h0);
      chk("rst_rdata", bus.mem_rdata, 32'h0);
      rst_n = 1'b1;

      // register vectors: reads compare rdata, all must complete in one cycle
      tbl.push_back('{A_DIV,  32'h0,         4'h0, 32'd139,        "div_rst"});
      tbl.push_back('{A_STAT, 32'h0,         4'h0, 32'h0,          "stat_rst"});
      tbl.push_back('{A_DATA, 32'h0,         4'h0, 32'hFFFF_FFFF,  "data_empty"});
      tbl.push_back('{A_RSVD, 32'h0,         4'h0, 32'h0,          "rsvd_rd"});
      tbl.push_back('{A_RSVD, 32'hDEAD_BEEF, 4'hF, 32'h0,          "rsvd_wr"});
      tbl.push_back('{A_RSVD, 32'h0,         4'h0, 32'h0,          "rsvd_rd2"});
      tbl.push_back('{A_DIV,  32'h2,         4'hF, 32'h0,          "div_wr2"});
      tbl.push_back('{A_DIV,  32'h0,         4'h0, 32'd4,          "div_clamp"});
      tbl.push_back('{A_DIV,  32'h0001_2345, 4'hF, 32'h0,          "div_wrbig"});
      tbl.push_back('{A_DIV,  32'h0,         4'h0, 32'h2345,       "div_16b"});
      tbl.push_back('{A_DIV,  32'h0000_00AB, 4'h1, 32'h0,          "div_wrlo"});
      tbl.push_back('{A_DIV,  32'h0,         4'h0, 32'h23AB,       "div_bytelane"});
      tbl.push_back('{A_STAT, 32'h1F,        4'hF, 32'h0,          "stat_wr"});
      tbl.push_back('{A_STAT, 32'h0,         4'h0, 32'h0,          "stat_ro"});
      tbl.push_back('{A_DIV,  32'd16,        4'hF, 32'h0,          "div_wr16"});
      tbl.push_back('{A_DIV,  32'h0,         4'h0, 32'd16,         "div_16"});
      for (int i = 0; i < tbl.size(); i++) begin
         bus_xfer(tbl[i].r, tbl[i].wd, tbl[i].ws, rd, cyc);
         chk({tbl[i].nm, "_cyc"}, cyc, 1);
         if (tbl[i].ws == 4'h0) chk(tbl[i].nm, rd, tbl[i].exp);
      end

      // 0x55 frame, then a second write that stalls until the first stop bit ends
      bus_xfer(A_DATA, 32'h55, 4'hF, rd, cyc);
      chk("tx55_cyc", cyc, 1);
      fork
         begin
            tx_frame_chk(8'h55, 16, 1, "tx55");
            tx_frame_chk(8'hC3, 16, 3, "txC3");
         end
         begin
            bus_xfer(A_DATA, 32'hC3, 4'hF, rd, cyc);
            chk("stall_cyc", cyc, 10 * 16 + 1);
         end
      join
      repeat (4) @(negedge clk);

      // tx_busy during and after a frame
      wr(A_DATA, 32'hA5);
      rd_chk(A_STAT, 32'h1, "busy_during");
      repeat (170) @(negedge clk);
      rd_chk(A_STAT, 32'h0, "busy_after");

      // RX 0xA3
      rx_send(8'hA3, 1'b1, 16);
      model_push(8'hA3);
      status_chk("rx_a3_stat");
      pop_chk("rx_a3");
      pop_chk("rx_a3_empty");

      // 5 bytes with no reads: storage fills, later bytes overrun
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom);
         rx_send(b, 1'b1, 16);
         model_push(b);
      end
      rd_chk(A_STAT, 32'h0E, "ovr_stat");
      for (int i = 0; i < DEPTH + 1; i++) pop_chk($sformatf("ovr_pop%0d", i));
      wr(A_STAT, 32'h8);
      m_ovr = 1'b0;
      status_chk("ovr_clr");

      // bad stop bit, then a short glitch
      rx_send(8'h5A, 1'b0, 16);
      m_fe = 1'b1;
      rd_chk(A_STAT, 32'h10, "fe_stat");
      pop_chk("fe_nodata");
      wr(A_STAT, 32'h10);
      m_fe = 1'b0;
      uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      status_chk("glitch_stat");
      pop_chk("glitch_nodata");

      // randomized divider, RX bytes, optional reads and TX bytes
      for (int it = 0; it < 8; it++) begin
         div = $urandom_range(20, 6);
         wr(A_DIV, div);
         b = 8'($urandom);
         rx_send(b, 1'b1, div);
         model_push(b);
         status_chk($sformatf("rnd%0d_stat", it));
         if ($urandom_range(1, 0) == 1) pop_chk($sformatf("rnd%0d_pop", it));
         b = 8'($urandom);
         wr(A_DATA, {24'h0, b});
         tx_frame_chk(b, div, 1, $sformatf("rnd%0d_tx", it));
         repeat (3) @(negedge clk);
      end
      while (model_q.size() > 0) pop_chk("drain");
      pop_chk("drain_empty");

      // reset in the middle of a TX frame
      wr(A_DATA, 32'h00);
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_tx", {31'h0, uart_tx}, 32'h1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_ovr = 1'b0;
      m_fe = 1'b0;
      rd_chk(A_DIV, 32'd139, "rst_mid_div");
      status_chk("rst_mid_stat");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
